// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op codes shared by the multiply/divide unit and its users
package muldiv_unit_pkg;
   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MTHI  = 3'd4,
      MTLO  = 3'd5
   } muldiv_op_t;
   localparam int MULDIV_OPS = 6;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide with HI/LO registers
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter bit FAST_MUL = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  muldiv_op_t       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
   logic [1:0] state;
   muldiv_op_t op_r;
   logic sa, sb;
   logic [WIDTH-1:0] ma, mb;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0] cnt;
   logic sgn_in, a_neg, b_neg, is_mul, last, dz;
   logic [WIDTH-1:0] abs_a, abs_b, q, r, hi_fix, lo_fix;
   logic [WIDTH:0] msum, r_sh, diff;
   logic [2*WIDTH-1:0] step, prod;
   always_comb begin
      sgn_in = (op == MULT) || (op == DIV);
      a_neg  = sgn_in & a[WIDTH-1];
      b_neg  = sgn_in & b[WIDTH-1];
      abs_a  = a_neg ? -a : a;
      abs_b  = b_neg ? -b : b;
      is_mul = !op_r[1];
      // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
      msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? ma : '0};
      r_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff   = r_sh - {1'b0, mb};
      step   = !is_mul ? {diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], !diff[WIDTH]}
             : FAST_MUL ? {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb}
             : {msum, acc[WIDTH-1:1]};
      last   = (is_mul && FAST_MUL) || (cnt == CW'(WIDTH - 1));
      dz     = (mb == '0);
      prod   = (sa ^ sb) ? -acc : acc;
      q      = acc[WIDTH-1:0];
      r      = acc[2*WIDTH-1:WIDTH];
      hi_fix = is_mul ? prod[2*WIDTH-1:WIDTH] : dz ? (sa ? -ma : ma) : (sa ? -r : r);
      lo_fix = is_mul ? prod[WIDTH-1:0] : dz ? '1 : ((sa ^ sb) ? -q : q);
      busy   = (state != IDLE);
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         op_r  <= MULT;
         sa    <= 1'b0;
         sb    <= 1'b0;
         ma    <= '0;
         mb    <= '0;
         acc   <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         dbz   <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            if (op == MTHI) hi <= a;
            else if (op == MTLO) lo <= a;
            else if (!op[2]) begin
               op_r  <= op;
               sa    <= a_neg;
               sb    <= b_neg;
               ma    <= abs_a;
               mb    <= abs_b;
               acc   <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
               cnt   <= '0;
               state <= (op[1] && b == '0) ? FIX : RUN;
            end
         end else if (state == RUN) begin
            acc <= step;
            cnt <= cnt + 1'b1;
            if (last) state <= FIX;
         end else if (state == FIX) begin
            hi    <= hi_fix;
            lo    <= lo_fix;
            done  <= 1'b1;
            dbz   <= !is_mul && dz;
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of the multiply/divide unit, iterative and fast-multiply builds
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;
   logic clock = 1'b0, reset = 1'b1;
   logic start = 1'b0, start1 = 1'b0;
   muldiv_op_t op = MULT, op1 = MULT;
   logic [31:0] a = '0, b = '0, a1 = '0, b1 = '0;
   logic busy, done, dbz, busy1, done1, dbz1;
   logic [31:0] hi, lo, hi1, lo1;
   int passes = 0, total = 0, lat, seen;
   always #5 clock = ~clock;
   muldiv_unit #(.WIDTH(32), .FAST_MUL(0)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
   );
   muldiv_unit #(.WIDTH(32), .FAST_MUL(1)) dut_fast (
      .clock(clock), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .dbz(dbz1), .hi(hi1), .lo(lo1)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic accept(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clock);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clock);
      #1 start = 1'b0;
   endtask
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 100) begin
         @(posedge clock);
         #1 n++;
      end
   endtask
   task automatic run_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y, output int n);
      accept(o, x, y);
      wait_done(n);
   endtask
   initial begin
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_dbz", dbz, 0);
      chk("reset_hilo", {hi, lo}, 64'h0);
      accept(MULTU, 32'hFFFFFFFF, 32'd2);
      chk("multu_busy", busy, 1);
      chk("multu_hold", {hi, lo}, 64'h0);
      wait_done(lat);
      chk("multu_latency", lat, 33);
      chk("multu_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);
      chk("multu_dbz", dbz, 0);
      run_op(MULT, 32'hFFFFFFFD, 32'd7, lat);
      chk("mult_latency", lat, 33);
      chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
      @(negedge clock);
      start1 = 1'b1; op1 = MULT; a1 = 32'hFFFFFFFD; b1 = 32'd7;
      @(posedge clock);
      #1 start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 100) begin
         @(posedge clock);
         #1 lat++;
      end
      chk("fast_latency", lat, 2);
      chk("fast_hilo", {hi1, lo1}, 64'hFFFFFFFF_FFFFFFEB);
      run_op(DIV, 32'hFFFFFFF9, 32'd2, lat);
      chk("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      run_op(DIVU, 32'd7, 32'd2, lat);
      chk("divu_hilo", {hi, lo}, 64'h00000001_00000003);
      run_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat);
      chk("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);
      chk("div_ovf_dbz", dbz, 0);
      run_op(DIV, 32'd5, 32'd0, lat);
      chk("dbz_latency", lat, 1);
      chk("dbz_flag", dbz, 1);
      chk("dbz_hilo", {hi, lo}, 64'h00000005_FFFFFFFF);
      run_op(DIV, 32'd7, 32'd2, lat);
      chk("div_after_dbz_flag", dbz, 0);
      chk("div_after_dbz_hilo", {hi, lo}, 64'h00000001_00000003);
      accept(MTHI, 32'h1234, 32'd0);
      chk("mthi_hi", hi, 32'h1234);
      chk("mthi_busy", busy, 0);
      accept(MTLO, 32'h5678, 32'd0);
      chk("mtlo_lo", lo, 32'h5678);
      accept(DIVU, 32'd100, 32'd7);
      repeat (3) @(posedge clock);
      accept(MULT, 32'd9, 32'd9);
      chk("busy_hold_hilo", {hi, lo}, 64'h00001234_00005678);
      wait_done(lat);
      chk("busy_ignore_hilo", {hi, lo}, 64'h00000002_0000000E);
      @(posedge clock);
      #1 chk("busy_ignore_idle", busy, 0);
      accept(muldiv_op_t'(3'd6), 32'hDEAD, 32'hBEEF);
      chk("op6_busy", busy, 0);
      chk("op6_hilo", {hi, lo}, 64'h00000002_0000000E);
      accept(MULTU, 32'd3, 32'd5);
      repeat (9) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_hilo", {hi, lo}, 64'h0);
      seen = 0;
      repeat (40) begin
         @(posedge clock);
         #1 if (done) seen++;
      end
      chk("abort_no_done", seen, 0);
      run_op(MULTU, 32'd3, 32'd5, lat);
      chk("fresh_latency", lat, 33);
      chk("fresh_hilo", {hi, lo}, 64'h00000000_0000000F);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
